// File: rtl/rc4_pkg.sv
// Shared RC4 constants and the decryptor (PRGA) state encoding.
package rc4_pkg;

  localparam int unsigned S_DEPTH = 256;
  localparam int unsigned S_AW    = 8;
  localparam int unsigned DW      = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SI,
    ST_WAIT_SI,
    ST_RD_SJ,
    ST_WAIT_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_F,
    ST_WAIT_F,
    ST_WR_DEC,
    ST_DONE
  } rc4_dec_state_t;

endpackage

// File: rtl/rc4_decryptor.sv
// RC4 keystream generator: swaps S entries, XORs keystream with the encrypted ROM,
// writes plaintext to the decrypted RAM. Nine cycles per message byte.
module rc4_decryptor
  import rc4_pkg::*;
#(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DW-1:0]     s_q,
  input  logic [DW-1:0]     enc_q,
  output logic [S_AW-1:0]   s_address,
  output logic [DW-1:0]     s_data,
  output logic              s_wren,
  output logic [MSG_AW-1:0] enc_address,
  output logic [MSG_AW-1:0] dec_address,
  output logic [DW-1:0]     dec_data,
  output logic              dec_wren,
  output logic              done
);

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  rc4_dec_state_t state, state_d;

  logic [S_AW-1:0]   i, j;
  logic [MSG_AW-1:0] k;
  logic [DW-1:0]     si, sj, f, e;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:    if (start) state_d = ST_RD_SI;
      ST_RD_SI:   state_d = ST_WAIT_SI;
      ST_WAIT_SI: state_d = ST_RD_SJ;
      ST_RD_SJ:   state_d = ST_WAIT_SJ;
      ST_WAIT_SJ: state_d = ST_WR_SI;
      ST_WR_SI:   state_d = ST_WR_SJ;
      ST_WR_SJ:   state_d = ST_RD_F;
      ST_RD_F:    state_d = ST_WAIT_F;
      ST_WAIT_F:  state_d = ST_WR_DEC;
      ST_WR_DEC:  state_d = (k == K_LAST) ? ST_DONE : ST_RD_SI;
      ST_DONE:    state_d = ST_DONE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Index and data-holding registers; memory data is captured in the WAIT states
  always_ff @(posedge clk) begin
    if (rst) begin
      i  <= '0;
      j  <= '0;
      k  <= '0;
      si <= '0;
      sj <= '0;
      f  <= '0;
      e  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            i <= S_AW'(1);
            j <= '0;
            k <= '0;
          end
        end
        ST_WAIT_SI: begin
          si <= s_q;
          j  <= j + s_q;
        end
        ST_WAIT_SJ: sj <= s_q;
        ST_WAIT_F: begin
          f <= s_q;
          e <= enc_q;
        end
        ST_WR_DEC: begin
          if (k != K_LAST) begin
            k <= k + MSG_AW'(1);
            i <= i + S_AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    s_address = '0;
    s_data    = '0;
    s_wren    = 1'b0;
    dec_data  = '0;
    dec_wren  = 1'b0;
    case (state)
      ST_RD_SI, ST_WAIT_SI: s_address = i;
      ST_RD_SJ, ST_WAIT_SJ: s_address = j;
      ST_WR_SI: begin
        s_address = i;
        s_data    = sj;
        s_wren    = 1'b1;
      end
      ST_WR_SJ: begin
        s_address = j;
        s_data    = si;
        s_wren    = 1'b1;
      end
      ST_RD_F, ST_WAIT_F: s_address = si + sj;
      ST_WR_DEC: begin
        dec_data = f ^ e;
        dec_wren = 1'b1;
      end
      default: ;
    endcase
  end

  assign enc_address = k;
  assign dec_address = k;
  assign done        = (state == ST_DONE);

endmodule

// File: tb/tb_rc4_decryptor.sv
// Directed bench for rc4_decryptor with behavioural S/ROM/RAM memories and an RC4 reference.
module tb_rc4_decryptor;

  localparam int unsigned MSG_LEN = 32;
  localparam int unsigned MSG_AW  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        s_q, enc_q;
  logic [7:0]        s_address, s_data, dec_data;
  logic              s_wren, dec_wren, done;
  logic [MSG_AW-1:0] enc_address, dec_address;

  logic [7:0] s_mem   [256];
  logic [7:0] enc_mem [MSG_LEN];
  logic [7:0] dec_mem [MSG_LEN];
  logic [7:0] ref_s   [256];
  logic [7:0] ref_out [MSG_LEN];
  logic [7:0] key     [3] = '{8'h4B, 8'h65, 8'h79};
  logic [7:0] enc_vec [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  logic [7:0] pt_vec  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

  int n_checks = 0;
  int n_pass   = 0;
  int done_edge, n_dec, n_swr, n_bad;
  logic [7:0] snap1, snap2, snap3;

  rc4_decryptor #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .s_q(s_q), .enc_q(enc_q),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
    .enc_address(enc_address), .dec_address(dec_address),
    .dec_data(dec_data), .dec_wren(dec_wren), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories, one cycle latency
  always @(posedge clk) begin
    if (s_wren) s_mem[s_address] <= s_data;
    if (dec_wren) dec_mem[dec_address] <= dec_data;
    s_q   <= s_mem[s_address];
    enc_q <= enc_mem[enc_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic load_ksa();
    logic [7:0] jj, t;
    jj = 8'd0;
    for (int n = 0; n < 256; n++) s_mem[n] = 8'(n);
    for (int n = 0; n < 256; n++) begin
      jj = jj + s_mem[n] + key[n % 3];
      t = s_mem[n]; s_mem[n] = s_mem[jj]; s_mem[jj] = t;
    end
  endtask

  // Textbook PRGA on a copy of the current S memory
  task automatic run_model();
    logic [7:0] ii, jj, t;
    ii = 8'd0; jj = 8'd0;
    for (int n = 0; n < 256; n++) ref_s[n] = s_mem[n];
    for (int n = 0; n < int'(MSG_LEN); n++) begin
      ii = ii + 8'd1;
      jj = jj + ref_s[ii];
      t = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = t;
      t = ref_s[ii] + ref_s[jj];
      ref_out[n] = ref_s[t] ^ enc_mem[n];
    end
  endtask

  task automatic compare_model(input string name);
    for (int n = 0; n < int'(MSG_LEN); n++)
      check($sformatf("%s_dec%0d", name, n), 32'(dec_mem[n]), 32'(ref_out[n]));
  endtask

  // Starts at a negedge; edge e is the e-th rising edge after the start-sampling edge
  task automatic run_msg(input string name);
    int e;
    bit fin;
    n_dec = 0; n_swr = 0; n_bad = 0; done_edge = -1;
    for (int n = 0; n < int'(MSG_LEN); n++) dec_mem[n] = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = 0; fin = 1'b0;
    check({name, "_first_addr"}, 32'(s_address), 32'h1);
    while (!fin) begin
      if (s_wren) n_swr++;
      if (dec_wren) begin
        n_dec++;
        if (e % 9 != 8 || dec_address != MSG_AW'((e - 8) / 9)) n_bad++;
      end
      if (done) begin
        done_edge = e; fin = 1'b1;
      end else if (e >= 400) begin
        check({name, "_timeout"}, 32'(done), 32'h1);
        fin = 1'b1;
      end else begin
        @(negedge clk);
        e++;
      end
      if (dec_wren && dec_address == MSG_AW'(1)) begin
        snap1 = s_mem[1]; snap2 = s_mem[2]; snap3 = s_mem[3];
      end
    end
    check({name, "_done_edge"}, 32'(done_edge), 32'd288);
    check({name, "_dec_pulses"}, 32'(n_dec), 32'd32);
    check({name, "_swren_pulses"}, 32'(n_swr), 32'd64);
    check({name, "_dec_timing"}, 32'(n_bad), 32'd0);
  endtask

  task automatic idle_outputs_zero(input string tag);
    check(tag, {s_address, s_data, 7'd0, s_wren, 3'd0, enc_address, 3'd0, dec_address,
                dec_data, 6'd0, dec_wren, done}, 64'd0);
  endtask

  initial begin
    int bad;
    for (int n = 0; n < 256; n++) s_mem[n] = 8'(n);
    for (int n = 0; n < int'(MSG_LEN); n++) enc_mem[n] = 8'h00;
    repeat (3) @(negedge clk);
    idle_outputs_zero("reset_outputs");
    rst = 1'b0;

    // Idle with start low
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if ({s_address, s_data, s_wren, enc_address, dec_address, dec_data, dec_wren, done} != '0)
        bad++;
    end
    check("idle_50_cycles", 32'(bad), 32'd0);

    // Identity S, zero ciphertext
    run_model();
    run_msg("ident");
    check("ident_dec0", 32'(dec_mem[0]), 32'h02);
    check("ident_dec1", 32'(dec_mem[1]), 32'h05);
    check("ident_s1", 32'(snap1), 32'h01);
    check("ident_s2", 32'(snap2), 32'h03);
    check("ident_s3", 32'(snap3), 32'h02);
    compare_model("ident");

    // DONE is sticky and ignores start
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (s_wren || dec_wren || !done) bad++;
      @(negedge clk);
    end
    check("done_sticky", 32'(bad), 32'd0);

    // Key "Key", known RC4 vector; j and si+sj wrap past 0xFF throughout
    rst = 1'b1;
    @(negedge clk);
    idle_outputs_zero("reset_from_done");
    rst = 1'b0;
    load_ksa();
    for (int n = 0; n < int'(MSG_LEN); n++) enc_mem[n] = (n < 9) ? enc_vec[n] : 8'(n * 37);
    run_model();
    @(negedge clk);
    run_msg("key");
    for (int n = 0; n < 9; n++)
      check($sformatf("plaintext%0d", n), 32'(dec_mem[n]), 32'(pt_vec[n]));
    compare_model("key");

    // Reset during byte 5 WR_SI, then restart from the mutated S
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load_ksa();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    check("byte5_wr_si_wren", 32'(s_wren), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    idle_outputs_zero("midrun_reset");
    rst = 1'b0;
    @(negedge clk);
    idle_outputs_zero("midrun_idle");
    run_model();
    run_msg("restart");
    compare_model("restart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
